// File: rtl/z_rr_mux_reg.sv
// z_rr_mux_reg: NUM_CH-to-1 valid/ready multiplexer with a single registered output stage.
// The channel is picked by `sel` (mode=0) or by a round-robin search after the last winner (mode=1).
module z_rr_mux_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]        out_data_r;
  logic [SEL_W-1:0]        out_ch_r;
  logic                    out_valid_r;
  logic [SEL_W-1:0]        last_r;

  logic                    can_load_s;
  logic                    grant_vld_s;
  logic [SEL_W-1:0]        grant_s;
  logic [NUM_CH-1:0]       in_ready_s;
  logic                    xfer_in_s;
  logic [NUM_CH*WIDTH-1:0] data_shift_s;
  logic [WIDTH-1:0]        grant_data_s;

  // Channel grant: fixed index match, or first valid channel after last_r with wrap-around.
  always_comb begin : grant_comb
    int                idx_v;
    logic [NUM_CH-1:0] vshift_v;
    logic              hit_v;
    idx_v       = 0;
    vshift_v    = {NUM_CH{1'b0}};
    hit_v       = 1'b0;
    grant_s     = {SEL_W{1'b0}};
    grant_vld_s = 1'b0;
    if (mode == 1'b0) begin
      // An out-of-range sel matches no channel and therefore yields no grant.
      for (int i = 0; i < NUM_CH; i++) begin
        hit_v       = (sel == SEL_W'(i)) && in_valid[i];
        grant_s     = hit_v ? SEL_W'(i) : grant_s;
        grant_vld_s = grant_vld_s | hit_v;
      end
    end else begin
      // The search ends at last_r itself, so a lone requester keeps winning.
      for (int k = 1; k <= NUM_CH; k++) begin
        idx_v       = (int'(last_r) + k) % NUM_CH;
        vshift_v    = in_valid >> idx_v;
        hit_v       = vshift_v[0] && !grant_vld_s;
        grant_s     = hit_v ? SEL_W'(idx_v) : grant_s;
        grant_vld_s = grant_vld_s | hit_v;
      end
    end
  end

  // Handshake: ready only to the granted channel when the output stage can accept a word.
  always_comb begin : ready_comb
    can_load_s = !out_valid_r || out_ready;
    in_ready_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready_s[i] = can_load_s && grant_vld_s && (grant_s == SEL_W'(i));
    end
    xfer_in_s    = |(in_valid & in_ready_s);
    data_shift_s = in_data >> (int'(grant_s) * WIDTH);
    grant_data_s = data_shift_s[WIDTH-1:0];
  end

  // Output register and round-robin pointer; reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_ch_r    <= {SEL_W{1'b0}};
      last_r      <= SEL_W'(NUM_CH - 1);
    end else begin
      if (xfer_in_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= grant_data_s;
        out_ch_r    <= grant_s;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      // Fixed-mode transfers leave the round-robin history untouched.
      if (xfer_in_s && mode) begin
        last_r <= grant_s;
      end else begin
        last_r <= last_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;

endmodule
